// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_buffer
//  Brief    : Instruction queue between the IF and ID stages. Each entry holds
//             {instruction, PC+4}. Lets decode stall without losing fetched
//             words, and flushes on a taken branch so that no wrong-path
//             instruction reaches decode.
//  Ports    : Clock    - rising-edge clock
//             Reset    - asynchronous active-high reset, clears all state
//             Flush    - taken-branch flush, discards every entry
//             InValid  - IF presents a fetched word this cycle
//             InInstr  - fetched instruction
//             InPCInc  - PC+4 of the fetched instruction
//             InReady  - queue can accept a word (IF holds its PC while low)
//             OutValid - head entry is present for ID
//             OutInstr - head instruction, NOP while the queue is empty
//             OutPCInc - head PC+4, zero while the queue is empty
//             OutReady - ID consumes the head this cycle
//             Count    - number of occupied entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
    parameter int          DEPTH = 2,            // power of 2, >= 2
    parameter logic [31:0] NOP   = 32'h00000000  // driven on OutInstr when empty
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Flush,
    input  logic                         InValid,
    input  logic [31:0]                  InInstr,
    input  logic [31:0]                  InPCInc,
    output logic                         InReady,
    output logic                         OutValid,
    output logic [31:0]                  OutInstr,
    output logic [31:0]                  OutPCInc,
    input  logic                         OutReady,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    // Entry layout: [63:32] instruction, [31:0] PC+4.
    logic [63:0]        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic [63:0]        w_head;

    // Ready depends on occupancy only: a full queue refuses a push even when
    // the head is popped in the same cycle, which keeps IF's stall path short.
    assign InReady  = (r_count != c_full);
    assign OutValid = (r_count != '0);

    // Flush wins over both handshakes, so the word presented alongside a
    // flush is dropped and nothing is consumed.
    assign w_push   = InValid  & InReady  & ~Flush;
    assign w_pop    = OutValid & OutReady & ~Flush;

    // Stale array contents survive flush/reset; mask them while empty.
    assign w_head   = r_mem[r_rd_ptr];
    assign OutInstr = OutValid ? w_head[63:32] : NOP;
    assign OutPCInc = OutValid ? w_head[31:0]  : 32'h0;
    assign Count    = r_count;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {InInstr, InPCInc};
        end
    end

    // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of 2).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_buffer
//  Brief    : Directed self-checking bench for if_id_buffer (DEPTH = 2):
//             reset, fill/ignore, streaming, flush, full+pop, wrap scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    logic        Clock;
    logic        Reset;
    logic        Flush;
    logic        InValid;
    logic [31:0] InInstr;
    logic [31:0] InPCInc;
    logic        InReady;
    logic        OutValid;
    logic [31:0] OutInstr;
    logic [31:0] OutPCInc;
    logic        OutReady;
    logic [1:0]  Count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model [$];

    if_id_buffer #(
        .DEPTH (2),
        .NOP   (32'h00000000)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InInstr  (InInstr),
        .InPCInc  (InPCInc),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutInstr (OutInstr),
        .OutPCInc (OutPCInc),
        .OutReady (OutReady),
        .Count    (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] instr, input logic [31:0] pc);
        InValid = 1'b1;
        InInstr = instr;
        InPCInc = pc;
        tick();
        InValid = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_count"},   64'(Count),    64'd0);
        check_val({tag, "_ovalid"},  64'(OutValid), 64'd0);
        check_val({tag, "_oinstr"},  64'(OutInstr), 64'd0);
        check_val({tag, "_opcinc"},  64'(OutPCInc), 64'd0);
        check_val({tag, "_inready"}, 64'(InReady),  64'd1);
    endtask

    initial begin
        Reset    = 1'b1;
        Flush    = 1'b0;
        InValid  = 1'b0;
        InInstr  = 32'h0;
        InPCInc  = 32'h0;
        OutReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        check_empty("reset");

        // ---- Fill: two pushes, third refused, then ordered pops ----
        push_word(32'h20010005, 32'd4);
        check_val("fill1_count", 64'(Count),    64'd1);
        check_val("fill1_instr", 64'(OutInstr), 64'h20010005);
        check_val("fill1_pcinc", 64'(OutPCInc), 64'd4);
        push_word(32'h20020007, 32'd8);
        check_val("fill2_count",   64'(Count),   64'd2);
        check_val("fill2_inready", 64'(InReady), 64'd0);
        push_word(32'hDEADBEEF, 32'd12);
        check_val("fill3_count", 64'(Count),    64'd2);
        check_val("fill3_head",  64'(OutInstr), 64'h20010005);
        OutReady = 1'b1;
        tick();
        check_val("pop1_count", 64'(Count),    64'd1);
        check_val("pop1_instr", 64'(OutInstr), 64'h20020007);
        check_val("pop1_pcinc", 64'(OutPCInc), 64'd8);
        tick();
        OutReady = 1'b0;
        check_empty("pop2");

        // ---- Asynchronous reset mid-stream with two entries ----
        push_word(32'hAAAA0001, 32'h100);
        push_word(32'hAAAA0002, 32'h104);
        check_val("prerst_count", 64'(Count), 64'd2);
        #2;
        Reset = 1'b1;
        #1;
        check_empty("asyncrst");
        #1;
        Reset = 1'b0;
        tick();
        check_empty("postrst");

        // ---- Stream: push and pop every cycle, one word per cycle ----
        InValid  = 1'b1;
        OutReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            InInstr = 32'h00001000 + 32'(k);
            InPCInc = 32'h00000200 + 32'(4 * k);
            tick();
            check_val($sformatf("stream%0d_count", k), 64'(Count), 64'd1);
            check_val($sformatf("stream%0d_instr", k), 64'(OutInstr),
                      64'(32'h00001000 + 32'(k)));
        end
        InValid = 1'b0;
        tick();
        OutReady = 1'b0;
        check_empty("stream_drain");

        // ---- Flush with a concurrent push ----
        push_word(32'hBBBB0001, 32'h10);
        push_word(32'hBBBB0002, 32'h14);
        Flush   = 1'b1;
        InValid = 1'b1;
        InInstr = 32'h11111111;
        InPCInc = 32'h18;
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        check_empty("flush_full");
        push_word(32'h22222222, 32'h40);
        check_val("flush_next_count", 64'(Count),    64'd1);
        check_val("flush_next_instr", 64'(OutInstr), 64'h22222222);
        // Flush while not full: the offered word must still be discarded.
        Flush    = 1'b1;
        InValid  = 1'b1;
        OutReady = 1'b1;
        InInstr  = 32'h33333333;
        tick();
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        check_empty("flush_part");

        // ---- Full + pop: push refused in the same cycle ----
        push_word(32'hCCCC0001, 32'h50);
        push_word(32'hCCCC0002, 32'h54);
        OutReady = 1'b1;
        InValid  = 1'b1;
        InInstr  = 32'h55555555;
        InPCInc  = 32'h58;
        #1;
        check_val("fullpop_inready", 64'(InReady), 64'd0);
        tick();
        InValid = 1'b0;
        check_val("fullpop_count", 64'(Count),    64'd1);
        check_val("fullpop_instr", 64'(OutInstr), 64'hCCCC0002);
        tick();
        OutReady = 1'b0;
        check_empty("fullpop_drain");

        // ---- Wrap: random stalls against a queue scoreboard ----
        begin
            int sent   = 0;
            int recv   = 0;
            int cycles = 0;
            logic iv, orr, exp_push, exp_pop;
            while (recv < 10 && cycles < 300) begin
                iv  = (sent < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
                orr = 1'($urandom_range(0, 1));
                InValid  = iv;
                OutReady = orr;
                InInstr  = 32'hA0000000 + 32'(sent);
                InPCInc  = 32'(4 * sent + 4);
                check_val("wrap_inready", 64'(InReady),
                          64'(model.size() < 2));
                exp_push = iv && (model.size() < 2);
                exp_pop  = orr && (model.size() > 0);
                if (exp_pop) begin
                    check_val("wrap_data", {OutInstr, OutPCInc}, model[0]);
                    void'(model.pop_front());
                    recv++;
                end
                if (exp_push) begin
                    model.push_back({InInstr, InPCInc});
                    sent++;
                end
                tick();
                check_val("wrap_count", 64'(Count), 64'(model.size()));
                check_val("wrap_max", 64'(Count <= 2'd2), 64'd1);
                cycles++;
            end
            InValid  = 1'b0;
            OutReady = 1'b0;
            check_val("wrap_done", 64'(recv), 64'd10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
